loopback_checker: RTL and testbench
===================================

LOOPBACK_CHECKER -- requirements
Module: loopback_checker

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows:
- NUM_CH, 2: number of independent receive channels.
- DATA_W, 32: word width.
- CNT_W, 32: counter width.
- LOCK_CNT, 4: consecutive predicted matches needed to lock.
- LOSS_CNT, 3: consecutive errors needed to drop lock.
- POLY, 32'h8000_0057: Galois LFSR feedback mask, DATA_W bits.

REQ-002 The design SHALL use one clock; reset is synchronous and active-high.

REQ-003 Ports (name, direction, width, meaning) SHALL be as follows:
- ACLK, in, 1: clock.
- ARESET, in, 1: synchronous active-high reset.
- en, in, 1: checker enable.
- clr, in, 1: clear counters and restart seek.
- mode, in, 1: pattern select; 0 = incrementing counter, 1 = LFSR.
- rx_valid, in, NUM_CH: per-channel word strobe.
- rx_data, in, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- lock, out, NUM_CH: channel locked.
- err_pulse, out, NUM_CH: one-cycle mismatch flag.
- word_cnt, out, NUM_CH*CNT_W: words checked while locked.
- err_cnt, out, NUM_CH*CNT_W: mismatching words while locked.
- any_err, out, 1: sticky OR of all channel errors.

Function
REQ-004 Each channel SHALL run its own FSM (IDLE, SEEK, LOCKED), with match/loss counters and an expected-word register; channels SHALL share only en, clr, mode and any_err.

REQ-005 The next-word function SHALL be:
- mode=0: next(x) = x+1 modulo 2^DATA_W.
- mode=1: next(x) = {x[DATA_W-2:0],1'b0} XOR (x[DATA_W-1] ? POLY : 0).

REQ-006 IDLE SHALL move to SEEK when en=1; any state SHALL move to IDLE within one cycle of en=0, and counters SHALL hold their values while en=0.

REQ-007 SEEK behaviour:
- The first valid word after entering SEEK primes expected = next(word) and sets match=0.
- Each later valid word equal to expected increments match and sets expected = next(word).
- A mismatching word re-primes from that word and sets match=0.

REQ-008 SEEK SHALL move to LOCKED on the valid word that makes match = LOCK_CNT; that word SHALL not be counted in word_cnt.

REQ-009 LOCKED behaviour, on each valid word:
- word_cnt increments.
- expected advances from expected (never from the received word), so a single corrupted word produces exactly one error.
- On mismatch: err_cnt increments, err_pulse is high for that channel in the following cycle, and any_err sets.
- On match: the loss counter clears.

REQ-010 LOCKED SHALL move to SEEK (lock=0, unprimed) on the valid word that makes consecutive mismatches = LOSS_CNT; that word SHALL still be counted as an error.

REQ-011 Latency: lock, err_pulse, word_cnt, err_cnt and any_err SHALL reflect a sampled word exactly one ACLK cycle after the cycle in which rx_valid is high.

REQ-012 word_cnt and err_cnt SHALL saturate at all-ones and never wrap.

REQ-013 When clr=1 with en=1:
- counters zero, any_err clears, and enabled channels go to SEEK unprimed, all in the next cycle.
- Any rx_valid word in the same cycle SHALL be discarded.
- clr SHALL take priority over all other events.

REQ-014 A change of mode while en=1 SHALL send every channel to SEEK unprimed on the next cycle, without clearing counters.

REQ-015 rx_valid low SHALL leave all channel state unchanged; back-to-back valid every cycle SHALL be supported at full rate.

REQ-016 An all-zero word in mode=1 is a legal LFSR value; it maps to itself and SHALL receive no special handling.

Reset
REQ-017 On ARESET=1 at a rising ACLK edge, the following SHALL hold, with ARESET taking priority over en, clr and mode:
- All channels go to IDLE.
- lock=0, err_pulse=0, word_cnt=0, err_cnt=0, any_err=0.
- Match/loss counters and expected registers are zeroed.

REQ-018 Reset asserted mid-stream SHALL discard any in-flight lock, and the first valid word after reset release plus en=1 SHALL prime SEEK.

Verification
(All scenarios: NUM_CH=2, DATA_W=8, CNT_W=8, LOCK_CNT=4, LOSS_CNT=3.)

REQ-019 Lock: mode=0, ch0 words 0x10..0x14 one per cycle -> lock[0]=1 one cycle after 0x14; word_cnt[0]=0, err_cnt[0]=0.

REQ-020 Single error: locked ch0 receives 0x15, 0xAA, 0x17, 0x18 -> exactly one err_pulse[0], err_cnt[0]=1, word_cnt[0]=4, lock stays 1, any_err=1.

REQ-021 Loss of lock: locked ch1 receives three consecutive wrong words -> err_cnt[1]=3, lock[1]=0 one cycle after the third; ch0 is unaffected.

REQ-022 LFSR mode: mode=1, POLY=8'h1D, seed 0x80 -> 0x1D, 0x3A, 0x74, 0xE8, 0xCD gives lock=1; flipping bit 0 of the next word gives err_cnt=1.

REQ-023 clr/valid collision: clr=1 in the same cycle as a valid word -> next cycle counters=0, any_err=0, lock=0; that word neither primes nor counts.

REQ-024 Saturation: force 300 locked words -> word_cnt holds at 0xFF; ARESET then drives all outputs to 0 in one cycle.

Source files
------------

// File: rtl/loopback_checker_if.sv
// loopback_checker_if -- receive word bus feeding the loopback checker.
//   rx_valid [NUM_CH]         per-channel word strobe
//   rx_data  [NUM_CH*DATA_W]  channel c occupies bits [c*DATA_W +: DATA_W]
// Modports: master drives words (pattern source), slave samples them (checker).
interface loopback_checker_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        rx_valid;
  logic [NUM_CH*DATA_W-1:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input rx_valid, input rx_data);
endinterface

// File: rtl/loopback_checker.sv
// loopback_checker -- multi-channel loopback pattern checker.
// Each channel seeks lock onto an incrementing-counter or Galois-LFSR word
// stream, then counts checked words and errors while locked.
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   en, clr, mode     enable, clear counters / restart seek, pattern select
//   rx (slave)        rx_valid / rx_data word bus
//   lock, err_pulse   per-channel lock state and one-cycle mismatch flag
//   word_cnt, err_cnt per-channel saturating counters, CNT_W bits each
//   any_err           sticky OR of all channel errors
module loopback_checker #(
  parameter int                NUM_CH   = 2,
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 32,
  parameter int                LOCK_CNT = 4,
  parameter int                LOSS_CNT = 3,
  parameter logic [DATA_W-1:0] POLY     = 32'h8000_0057
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      mode,
  loopback_checker_if.slave         rx,
  output logic [NUM_CH-1:0]         lock,
  output logic [NUM_CH-1:0]         err_pulse,
  output logic [NUM_CH*CNT_W-1:0]   word_cnt,
  output logic [NUM_CH*CNT_W-1:0]   err_cnt,
  output logic                      any_err
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK_CNT);
  localparam logic [LOSS_W-1:0]  LOSS_V = LOSS_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Successor of x in the selected pattern; an all-zero LFSR word maps to itself.
  function automatic logic [DATA_W-1:0] next_word(input logic m, input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (m) begin
      r = {x[DATA_W-2:0], 1'b0} ^ (x[DATA_W-1] ? POLY : {DATA_W{1'b0}});
    end else begin
      r = x + {{(DATA_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] r;
    if (&x) begin
      r = x;
    end else begin
      r = x + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic              mode_q;
  logic              any_err_q, any_err_d;
  logic              mode_chg_s;
  logic [NUM_CH-1:0] err_set_s;

  assign mode_chg_s = mode ^ mode_q;
  assign any_err    = any_err_q;

  // Shared registers: previous mode for change detection, sticky error flag.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mode_q    <= 1'b0;
      any_err_q <= 1'b0;
    end else begin
      mode_q    <= mode;
      any_err_q <= any_err_d;
    end
  end

  // Sticky error: clr wins, otherwise any channel mismatch sets it.
  always_comb begin
    any_err_d = any_err_q;
    if (en && clr) begin
      any_err_d = 1'b0;
    end else if (|err_set_s) begin
      any_err_d = 1'b1;
    end else begin
      any_err_d = any_err_q;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e             state_q, state_d;
    logic               primed_q, primed_d;
    logic [DATA_W-1:0]  exp_q, exp_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;
    logic               lock_q;
    logic               pulse_q, pulse_d;
    logic               valid_s;
    logic [DATA_W-1:0]  word_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic [LOSS_W-1:0]  loss_inc_s;

    assign valid_s     = rx.rx_valid[c];
    assign word_s      = rx.rx_data[c*DATA_W +: DATA_W];
    assign match_inc_s = match_q + MATCH_W'(1'b1);
    assign loss_inc_s  = loss_q + LOSS_W'(1'b1);
    assign err_set_s[c] = pulse_d;

    assign lock[c]                     = lock_q;
    assign err_pulse[c]                = pulse_q;
    assign word_cnt[c*CNT_W +: CNT_W]  = wcnt_q;
    assign err_cnt[c*CNT_W +: CNT_W]   = ecnt_q;

    // Channel state and registered outputs.
    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        state_q  <= ST_IDLE;
        primed_q <= 1'b0;
        exp_q    <= {DATA_W{1'b0}};
        match_q  <= {MATCH_W{1'b0}};
        loss_q   <= {LOSS_W{1'b0}};
        wcnt_q   <= {CNT_W{1'b0}};
        ecnt_q   <= {CNT_W{1'b0}};
        lock_q   <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        primed_q <= primed_d;
        exp_q    <= exp_d;
        match_q  <= match_d;
        loss_q   <= loss_d;
        wcnt_q   <= wcnt_d;
        ecnt_q   <= ecnt_d;
        lock_q   <= (state_d == ST_LOCKED);
        pulse_q  <= pulse_d;
      end
    end

    // Next state: disable > clr > mode change > received word.
    always_comb begin
      state_d  = state_q;
      primed_d = primed_q;
      exp_d    = exp_q;
      match_d  = match_q;
      loss_d   = loss_q;
      wcnt_d   = wcnt_q;
      ecnt_d   = ecnt_q;
      pulse_d  = 1'b0;
      if (!en) begin
        // Counters hold while disabled; only the lock search is abandoned.
        state_d  = ST_IDLE;
        primed_d = 1'b0;
        match_d  = {MATCH_W{1'b0}};
        loss_d   = {LOSS_W{1'b0}};
      end else if (clr || mode_chg_s) begin
        // Any word in this cycle is dropped; seek restarts unprimed.
        state_d  = ST_SEEK;
        primed_d = 1'b0;
        match_d  = {MATCH_W{1'b0}};
        loss_d   = {LOSS_W{1'b0}};
        if (clr) begin
          wcnt_d = {CNT_W{1'b0}};
          ecnt_d = {CNT_W{1'b0}};
        end else begin
          wcnt_d = wcnt_q;
          ecnt_d = ecnt_q;
        end
      end else if (!valid_s) begin
        if (state_q == ST_IDLE) begin
          state_d = ST_SEEK;
        end else begin
          state_d = state_q;
        end
      end else begin
        case (state_q)
          ST_IDLE, ST_SEEK: begin
            // A word arriving while still idle simply primes the search.
            state_d = ST_SEEK;
            if (primed_q && (state_q == ST_SEEK) && (word_s == exp_q)) begin
              match_d = match_inc_s;
              exp_d   = next_word(mode, word_s);
              if (match_inc_s == LOCK_V) begin
                state_d = ST_LOCKED;
                match_d = {MATCH_W{1'b0}};
                loss_d  = {LOSS_W{1'b0}};
              end else begin
                state_d = ST_SEEK;
              end
            end else begin
              primed_d = 1'b1;
              match_d  = {MATCH_W{1'b0}};
              exp_d    = next_word(mode, word_s);
            end
          end
          ST_LOCKED: begin
            // Expected free-runs from itself so one bad word costs one error.
            wcnt_d = sat_inc(wcnt_q);
            exp_d  = next_word(mode, exp_q);
            if (word_s == exp_q) begin
              loss_d = {LOSS_W{1'b0}};
            end else begin
              ecnt_d  = sat_inc(ecnt_q);
              pulse_d = 1'b1;
              if (loss_inc_s == LOSS_V) begin
                state_d  = ST_SEEK;
                primed_d = 1'b0;
                match_d  = {MATCH_W{1'b0}};
                loss_d   = {LOSS_W{1'b0}};
              end else begin
                loss_d = loss_inc_s;
              end
            end
          end
          default: begin
            state_d  = ST_IDLE;
            primed_d = 1'b0;
            match_d  = {MATCH_W{1'b0}};
            loss_d   = {LOSS_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loopback_checker.sv
// tb_loopback_checker -- directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the lock/count rules.
module tb_loopback_checker;
  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int LOCKN = 4;
  localparam int LOSSN = 3;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic mode = 1'b0;
  logic [NCH-1:0]    lock, err_pulse;
  logic [NCH*CW-1:0] word_cnt, err_cnt;
  logic              any_err;

  loopback_checker_if #(.NUM_CH(NCH), .DATA_W(DW)) rx_if ();

  loopback_checker #(
    .NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW),
    .LOCK_CNT(LOCKN), .LOSS_CNT(LOSSN), .POLY(8'h1D)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .en(en), .clr(clr), .mode(mode),
    .rx(rx_if.slave),
    .lock(lock), .err_pulse(err_pulse),
    .word_cnt(word_cnt), .err_cnt(err_cnt), .any_err(any_err)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse [NCH];

  // Behavioural model state.
  bit m_locked [NCH];
  bit m_primed [NCH];
  bit m_pulse  [NCH];
  int m_exp    [NCH];
  int m_match  [NCH];
  int m_loss   [NCH];
  int m_wc     [NCH];
  int m_ec     [NCH];
  bit m_any;
  bit m_pmode;

  int gen [NCH];
  logic [NCH-1:0]    v_s;
  logic [NCH*DW-1:0] d_s;
  int tmp;
  logic [7:0] lfsr_seq [0:5] = '{8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD};

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int nxt(input int x, input bit m);
    if (m) return ((x * 2) % 256) ^ ((x >= 128) ? 'h1D : 0);
    return (x + 1) % 256;
  endfunction

  function automatic int sat(input int x);
    return (x >= 255) ? 255 : x + 1;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit chg;
    bit anyset;
    int w;
    if (ARESET) begin
      for (int c = 0; c < NCH; c++) begin
        m_locked[c] = 0; m_primed[c] = 0; m_pulse[c] = 0; m_exp[c] = 0;
        m_match[c] = 0; m_loss[c] = 0; m_wc[c] = 0; m_ec[c] = 0;
      end
      m_any = 0;
      m_pmode = 0;
      return;
    end
    chg = (mode != m_pmode);
    m_pmode = mode;
    anyset = 0;
    for (int c = 0; c < NCH; c++) begin
      m_pulse[c] = 0;
      if (!en || clr || chg) begin
        m_locked[c] = 0; m_primed[c] = 0; m_match[c] = 0; m_loss[c] = 0;
        if (en && clr) begin
          m_wc[c] = 0;
          m_ec[c] = 0;
        end
        continue;
      end
      if (!rx_if.rx_valid[c]) continue;
      w = int'(rx_if.rx_data[c*DW +: DW]);
      if (m_locked[c]) begin
        m_wc[c] = sat(m_wc[c]);
        if (w == m_exp[c]) begin
          m_loss[c] = 0;
        end else begin
          m_ec[c] = sat(m_ec[c]);
          m_pulse[c] = 1;
          anyset = 1;
          m_loss[c]++;
        end
        m_exp[c] = nxt(m_exp[c], mode);
        if (m_loss[c] == LOSSN) begin
          m_locked[c] = 0; m_primed[c] = 0; m_match[c] = 0; m_loss[c] = 0;
        end
      end else if (!m_primed[c] || w != m_exp[c]) begin
        m_primed[c] = 1;
        m_match[c] = 0;
        m_exp[c] = nxt(w, mode);
      end else begin
        m_match[c]++;
        m_exp[c] = nxt(w, mode);
        if (m_match[c] == LOCKN) begin
          m_locked[c] = 1;
          m_loss[c] = 0;
        end
      end
    end
    if (en && clr) m_any = 0;
    else m_any = m_any | anyset;
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_step();
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk_val($sformatf("lock%0d", c), 32'(lock[c]), 32'(m_locked[c]));
      chk_val($sformatf("err_pulse%0d", c), 32'(err_pulse[c]), 32'(m_pulse[c]));
      chk_val($sformatf("word_cnt%0d", c), 32'(word_cnt[c*CW +: CW]), m_wc[c]);
      chk_val($sformatf("err_cnt%0d", c), 32'(err_cnt[c*CW +: CW]), m_ec[c]);
      if (err_pulse[c]) n_pulse[c]++;
    end
    chk_val("any_err", 32'(any_err), 32'(m_any));
  endtask

  task automatic send(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    rx_if.rx_valid = v;
    rx_if.rx_data  = {d1, d0};
    tick();
    rx_if.rx_valid = 2'b00;
  endtask

  initial begin
    rx_if.rx_valid = 2'b00;
    rx_if.rx_data  = 16'h0000;
    n_pulse[0] = 0;
    n_pulse[1] = 0;

    // Reset state
    repeat (3) tick();
    chk_val("rst_lock", 32'(lock), 32'h0);
    chk_val("rst_cnt", 32'({word_cnt, err_cnt}), 32'h0);
    ARESET = 1'b0;
    en = 1'b1;
    tick();

    // Lock both channels in counter mode
    for (int i = 0; i < 5; i++) send(2'b11, 8'(8'h10 + i), 8'(8'h50 + i));
    chk_val("lock0_after_5", 32'(lock[0]), 32'h1);
    chk_val("lock1_after_5", 32'(lock[1]), 32'h1);
    chk_val("lock0_wcnt", 32'(word_cnt[7:0]), 32'h0);
    chk_val("lock0_ecnt", 32'(err_cnt[7:0]), 32'h0);

    // Single corrupted word on ch0
    n_pulse[0] = 0;
    send(2'b11, 8'h15, 8'h55);
    send(2'b11, 8'hAA, 8'h56);
    send(2'b11, 8'h17, 8'h57);
    send(2'b11, 8'h18, 8'h58);
    chk_val("single_err_pulses", n_pulse[0], 32'd1);
    chk_val("single_err_ecnt", 32'(err_cnt[7:0]), 32'h1);
    chk_val("single_err_wcnt", 32'(word_cnt[7:0]), 32'h4);
    chk_val("single_err_lock", 32'(lock[0]), 32'h1);
    chk_val("single_err_any", 32'(any_err), 32'h1);

    // Three wrong words on ch1 drop its lock; ch0 unaffected
    send(2'b11, 8'h19, 8'h00);
    send(2'b11, 8'h1A, 8'h00);
    chk_val("loss_lock1_held", 32'(lock[1]), 32'h1);
    send(2'b11, 8'h1B, 8'h00);
    chk_val("loss_ecnt1", 32'(err_cnt[15:8]), 32'h3);
    chk_val("loss_lock1", 32'(lock[1]), 32'h0);
    chk_val("loss_lock0", 32'(lock[0]), 32'h1);
    chk_val("loss_ecnt0", 32'(err_cnt[7:0]), 32'h1);

    // clr collides with a valid word
    clr = 1'b1;
    send(2'b11, 8'h1C, 8'h5C);
    clr = 1'b0;
    chk_val("clr_cnts", 32'({word_cnt, err_cnt}), 32'h0);
    chk_val("clr_any", 32'(any_err), 32'h0);
    chk_val("clr_lock", 32'(lock), 32'h0);
    for (int i = 0; i < 4; i++) send(2'b01, 8'(8'h1D + i), 8'h00);
    chk_val("clr_word_not_primed", 32'(lock[0]), 32'h0);
    send(2'b01, 8'h21, 8'h00);
    chk_val("clr_relock", 32'(lock[0]), 32'h1);

    // LFSR mode
    mode = 1'b1;
    tick();
    chk_val("mode_chg_unlock", 32'(lock[0]), 32'h0);
    for (int i = 0; i < 5; i++) send(2'b01, lfsr_seq[i], 8'h00);
    chk_val("lfsr_lock", 32'(lock[0]), 32'h1);
    send(2'b01, lfsr_seq[5], 8'h00);
    send(2'b01, 8'h86, 8'h00);
    chk_val("lfsr_flip_ecnt", 32'(err_cnt[7:0]), 32'h1);
    chk_val("lfsr_flip_lock", 32'(lock[0]), 32'h1);

    // Randomized traffic
    gen[0] = $urandom_range(0, 255);
    gen[1] = $urandom_range(0, 255);
    for (int n = 0; n < 3000; n++) begin
      ARESET = ($urandom_range(0, 499) == 0);
      en     = ($urandom_range(0, 49) != 0);
      clr    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      for (int c = 0; c < NCH; c++) begin
        v_s[c] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 299) == 0) gen[c] = $urandom_range(0, 255);
        tmp = gen[c];
        if ($urandom_range(0, 15) == 0) tmp = tmp ^ (1 << $urandom_range(0, 7));
        d_s[c*DW +: DW] = 8'(tmp);
        if (v_s[c]) gen[c] = nxt(gen[c], mode);
      end
      rx_if.rx_valid = v_s;
      rx_if.rx_data  = d_s;
      tick();
    end
    rx_if.rx_valid = 2'b00;

    // Saturation, then reset clears everything in one cycle
    ARESET = 1'b0;
    en = 1'b1;
    mode = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 305; i++) send(2'b01, 8'(i), 8'h00);
    chk_val("sat_wcnt", 32'(word_cnt[7:0]), 32'hFF);
    chk_val("sat_lock", 32'(lock[0]), 32'h1);
    ARESET = 1'b1;
    tick();
    chk_val("final_rst_lock", 32'(lock), 32'h0);
    chk_val("final_rst_pulse", 32'(err_pulse), 32'h0);
    chk_val("final_rst_wcnt", 32'(word_cnt), 32'h0);
    chk_val("final_rst_ecnt", 32'(err_cnt), 32'h0);
    chk_val("final_rst_any", 32'(any_err), 32'h0);
    ARESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
